// File: rtl/adc_capture_core.sv
// adc_capture_core
//   Multi-channel parallel-ADC front end. Raw samples and overrange bits are
//   registered, converted to two's complement (or kept offset-binary),
//   clamped to full scale on overrange, and presented continuously on
//   adc_data. Per-channel overrange status is kept as a sticky flag plus a
//   saturating counter. On request, a fixed-length burst of converted
//   samples is streamed on cap_data/cap_valid, and the per-channel peak
//   magnitude of each completed burst is reported on peak_abs.
//
// Ports
//   adc_clk100m  in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   adc_d        in   raw samples, channel k at [k*DW +: DW], offset-binary
//   adc_or       in   per-channel overrange, aligned with adc_d
//   cap_start    in   single-cycle capture request
//   cap_len      in   burst length in samples, sampled with cap_start
//   cap_abort    in   terminate capture (wins over cap_start)
//   or_clr       in   clear overrange status
//   adc_data     out  continuous converted samples (2-cycle latency)
//   cap_valid    out  burst sample qualifier
//   cap_data     out  burst samples
//   cap_busy     out  capture in progress
//   cap_done     out  one-cycle completion pulse
//   peak_abs     out  unsigned max |sample| per channel, last completed burst
//   or_sticky    out  sticky overrange flags
//   or_cnt       out  saturating overrange counts, channel k at [k*OR_CNT_W +: OR_CNT_W]

module adc_capture_core #(
    parameter int CH_NUM    = 2,
    parameter int DW        = 14,
    parameter int TWOS_COMP = 1,
    parameter int CLAMP_EN  = 1,
    parameter int CAP_LEN_W = 16,
    parameter int OR_CNT_W  = 16
) (
    input  logic                         adc_clk100m,
    input  logic                         rst_n,
    input  logic [CH_NUM*DW-1:0]         adc_d,
    input  logic [CH_NUM-1:0]            adc_or,
    input  logic                         cap_start,
    input  logic [CAP_LEN_W-1:0]         cap_len,
    input  logic                         cap_abort,
    input  logic                         or_clr,
    output logic [CH_NUM*DW-1:0]         adc_data,
    output logic                         cap_valid,
    output logic [CH_NUM*DW-1:0]         cap_data,
    output logic                         cap_busy,
    output logic                         cap_done,
    output logic [CH_NUM*DW-1:0]         peak_abs,
    output logic [CH_NUM-1:0]            or_sticky,
    output logic [CH_NUM*OR_CNT_W-1:0]   or_cnt
);

    localparam logic [DW-1:0]        MSB_MASK = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] TC_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] TC_MIN   = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {CAP_IDLE, CAP_RUN} cap_state_t;

    // Conversion and clamp are both done in the two's-complement domain;
    // offset-binary output is recovered by flipping the MSB back at the end.
    function automatic logic [DW-1:0] convert_sample(input logic [DW-1:0] raw,
                                                     input logic          ovr);
        logic signed [DW-1:0] tc;
        tc = raw ^ MSB_MASK;
        if ((CLAMP_EN != 0) && ovr)
            tc = tc[DW-1] ? TC_MIN : TC_MAX;
        return (TWOS_COMP != 0) ? tc : (tc ^ MSB_MASK);
    endfunction

    // Unsigned magnitude of a converted sample. The most negative value maps
    // to 2^(DW-1), which still fits in DW unsigned bits.
    function automatic logic [DW-1:0] sample_mag(input logic [DW-1:0] smp);
        logic [DW-1:0] tc;
        tc = (TWOS_COMP != 0) ? smp : (smp ^ MSB_MASK);
        return tc[DW-1] ? (~tc + DW'(1)) : tc;
    endfunction

    function automatic logic [OR_CNT_W-1:0] sat_inc(input logic [OR_CNT_W-1:0] c);
        return (&c) ? c : (c + OR_CNT_W'(1));
    endfunction

    logic [CH_NUM*DW-1:0]  d_p0;
    logic [CH_NUM-1:0]     or_p0;
    logic [CH_NUM*DW-1:0]  conv_p0;
    logic [CH_NUM*DW-1:0]  mag_p1;

    cap_state_t            cap_state;
    logic [CAP_LEN_W-1:0]  cap_remain;
    logic                  burst_end_p2;
    logic [CH_NUM*DW-1:0]  run_max_p2;

    // ---- Stage p0: input capture, nothing ahead of the flops ----
    always_ff @(posedge adc_clk100m) begin
        d_p0 <= adc_d;
    end

    always_ff @(posedge adc_clk100m or negedge rst_n) begin
        if (!rst_n) or_p0 <= '0;
        else        or_p0 <= adc_or;
    end

    // ---- Stage p1: conversion/clamp and overrange status ----
    always_comb begin
        conv_p0 = '0;
        for (int ch = 0; ch < CH_NUM; ch++)
            conv_p0[ch*DW +: DW] = convert_sample(d_p0[ch*DW +: DW], or_p0[ch]);
    end

    always_ff @(posedge adc_clk100m or negedge rst_n) begin
        if (!rst_n) adc_data <= '0;
        else        adc_data <= conv_p0;
    end

    // A clear coincident with a new overrange event keeps that event.
    always_ff @(posedge adc_clk100m or negedge rst_n) begin
        if (!rst_n) begin
            or_sticky <= '0;
            or_cnt    <= '0;
        end else begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                if (or_clr) begin
                    or_sticky[ch]                   <= or_p0[ch];
                    or_cnt[ch*OR_CNT_W +: OR_CNT_W] <= or_p0[ch] ? OR_CNT_W'(1) : '0;
                end else if (or_p0[ch]) begin
                    or_sticky[ch]                   <= 1'b1;
                    or_cnt[ch*OR_CNT_W +: OR_CNT_W] <= sat_inc(or_cnt[ch*OR_CNT_W +: OR_CNT_W]);
                end
            end
        end
    end

    // ---- Stage p2: burst capture and peak tracking ----
    always_comb begin
        mag_p1 = '0;
        for (int ch = 0; ch < CH_NUM; ch++)
            mag_p1[ch*DW +: DW] = sample_mag(adc_data[ch*DW +: DW]);
    end

    // burst_end_p2 marks that the last sample went out on the previous edge,
    // so cap_done and peak_abs land one cycle after the final cap_valid.
    always_ff @(posedge adc_clk100m or negedge rst_n) begin
        if (!rst_n) begin
            cap_state    <= CAP_IDLE;
            cap_remain   <= '0;
            burst_end_p2 <= 1'b0;
            run_max_p2   <= '0;
            cap_valid    <= 1'b0;
            cap_busy     <= 1'b0;
            cap_done     <= 1'b0;
            cap_data     <= '0;
            peak_abs     <= '0;
        end else begin
            case (cap_state)
                CAP_IDLE: begin
                    cap_valid    <= 1'b0;
                    cap_busy     <= 1'b0;
                    cap_done     <= burst_end_p2;
                    burst_end_p2 <= 1'b0;
                    if (burst_end_p2)
                        peak_abs <= run_max_p2;
                    if (cap_start && (cap_len != '0) && !cap_abort) begin
                        cap_state  <= CAP_RUN;
                        cap_remain <= cap_len;
                        run_max_p2 <= '0;
                    end
                end
                CAP_RUN: begin
                    cap_done <= 1'b0;
                    if (cap_abort) begin
                        cap_state <= CAP_IDLE;
                        cap_valid <= 1'b0;
                        cap_busy  <= 1'b0;
                    end else begin
                        cap_valid  <= 1'b1;
                        cap_busy   <= 1'b1;
                        cap_data   <= adc_data;
                        cap_remain <= cap_remain - CAP_LEN_W'(1);
                        for (int ch = 0; ch < CH_NUM; ch++) begin
                            if (mag_p1[ch*DW +: DW] > run_max_p2[ch*DW +: DW])
                                run_max_p2[ch*DW +: DW] <= mag_p1[ch*DW +: DW];
                        end
                        if (cap_remain == CAP_LEN_W'(1)) begin
                            cap_state    <= CAP_IDLE;
                            burst_end_p2 <= 1'b1;
                        end
                    end
                end
                default: cap_state <= CAP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_core.sv
// Bench for adc_capture_core: 2 channels, DW=14, two's-complement output,
// clamping on, 2-bit overrange counters so saturation is reachable.
module tb_adc_capture_core;

    localparam int CH_NUM    = 2;
    localparam int DW        = 14;
    localparam int CAP_LEN_W = 16;
    localparam int OR_CNT_W  = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [CH_NUM*DW-1:0]       adc_d;
    logic [CH_NUM-1:0]          adc_or;
    logic                       cap_start;
    logic [CAP_LEN_W-1:0]       cap_len;
    logic                       cap_abort;
    logic                       or_clr;
    logic [CH_NUM*DW-1:0]       adc_data;
    logic                       cap_valid;
    logic [CH_NUM*DW-1:0]       cap_data;
    logic                       cap_busy;
    logic                       cap_done;
    logic [CH_NUM*DW-1:0]       peak_abs;
    logic [CH_NUM-1:0]          or_sticky;
    logic [CH_NUM*OR_CNT_W-1:0] or_cnt;

    always #5 clk = ~clk;

    adc_capture_core #(
        .CH_NUM(CH_NUM), .DW(DW), .TWOS_COMP(1), .CLAMP_EN(1),
        .CAP_LEN_W(CAP_LEN_W), .OR_CNT_W(OR_CNT_W)
    ) dut (
        .adc_clk100m(clk), .rst_n(rst_n), .adc_d(adc_d), .adc_or(adc_or),
        .cap_start(cap_start), .cap_len(cap_len), .cap_abort(cap_abort),
        .or_clr(or_clr), .adc_data(adc_data), .cap_valid(cap_valid),
        .cap_data(cap_data), .cap_busy(cap_busy), .cap_done(cap_done),
        .peak_abs(peak_abs), .or_sticky(or_sticky), .or_cnt(or_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Independent reference: offset-binary minus mid-scale, clamp by sign.
    function automatic logic [DW-1:0] exp_conv(input logic [DW-1:0] raw, input logic ovr);
        int v;
        v = int'(raw) - 8192;
        if (ovr) v = (v >= 0) ? 8191 : -8192;
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] raw_of(input int v);
        return DW'(v + 8192);
    endfunction

    logic [CH_NUM*DW-1:0] q_adc[$];
    logic [CH_NUM*DW-1:0] q_cap[$];
    logic [CH_NUM*DW-1:0] exp_peak = '0;
    int                   n_valid = 0;
    int                   n_done  = 0;
    logic                 prev_valid = 1'b0;
    int                   s0[0:127];
    int                   s1[0:127];

    // Expected adc_data is pushed when the input is sampled and popped two edges later.
    always @(posedge clk) begin
        if (rst_n)
            q_adc.push_back({exp_conv(adc_d[27:14], adc_or[1]), exp_conv(adc_d[13:0], adc_or[0])});
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (q_adc.size() >= 2)
                chk("adc_data", adc_data, q_adc.pop_front());
            if (cap_valid) begin
                n_valid++;
                chk("cap_queue_nonempty", q_cap.size() != 0, 1'b1);
                if (q_cap.size() != 0)
                    chk("cap_data", cap_data, q_cap.pop_front());
            end
            if (cap_done) begin
                n_done++;
                chk("done_after_last_valid", prev_valid, 1'b1);
                chk("done_busy_valid_low", {cap_busy, cap_valid}, 2'b00);
                chk("peak_at_done", peak_abs, exp_peak);
            end
            prev_valid = cap_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives sample i of s0/s1 each cycle; cap_start at i==1 so the first
    // captured sample is sample 0. abort_k >= 0 aborts after abort_k samples.
    task automatic burst(input int len, input int abort_k, input int restart_i);
        int nv, m0, m1, a0, a1;
        nv = (abort_k >= 0) ? abort_k : len;
        m0 = 0;
        m1 = 0;
        for (int i = 0; i < nv; i++) begin
            q_cap.push_back({exp_conv(raw_of(s1[i]), 1'b0), exp_conv(raw_of(s0[i]), 1'b0)});
            a0 = (s0[i] < 0) ? -s0[i] : s0[i];
            a1 = (s1[i] < 0) ? -s1[i] : s1[i];
            if (a0 > m0) m0 = a0;
            if (a1 > m1) m1 = a1;
        end
        if (abort_k < 0) exp_peak = {DW'(m1), DW'(m0)};
        n_valid = 0;
        n_done  = 0;
        for (int i = 0; i < len + 6; i++) begin
            adc_d     = {raw_of(s1[i]), raw_of(s0[i])};
            cap_start = (i == 1) || (i == restart_i);
            cap_len   = CAP_LEN_W'(len);
            cap_abort = (abort_k >= 0) && (i == abort_k + 2);
            tick();
        end
        cap_start = 1'b0;
        cap_abort = 1'b0;
        chk("burst_valid_count", n_valid, nv);
        chk("burst_done_count", n_done, (abort_k < 0) ? 1 : 0);
        chk("burst_peak", peak_abs, exp_peak);
        chk("burst_queue_drained", q_cap.size(), 0);
        chk("burst_busy_low", cap_busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        adc_d = {14'h0000, 14'h3FFF};
        adc_or = '0;
        cap_start = 1'b0;
        cap_len = '0;
        cap_abort = 1'b0;
        or_clr = 1'b0;
        for (int i = 0; i < 128; i++) begin
            s0[i] = 0;
            s1[i] = 0;
        end
        #2 rst_n = 1'b0;

        // Reset state and format
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("rst_adc_data", adc_data, '0);
            chk("rst_ctrl", {cap_valid, cap_busy, cap_done, or_sticky}, '0);
            chk("rst_peak_cnt_capdata", {peak_abs, or_cnt, cap_data}, '0);
        end
        rst_n = 1'b1;
        tick();
        tick();
        chk("fmt_adc_data", adc_data, {14'h2000, 14'h1FFF});

        // Clamp and counter saturation: four overrange samples on ch0
        adc_d  = {14'h1234, 14'h2100};
        adc_or = 2'b01;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 4) adc_or = 2'b00;
            chk("or_cnt_ch0", or_cnt[1:0], (j - 1 > 3) ? 2'd3 : 2'(j - 1));
            chk("or_sticky", or_sticky, (j >= 2) ? 2'b01 : 2'b00);
            chk("or_cnt_ch1", or_cnt[3:2], 2'd0);
            if (j >= 2)
                chk("clamp_pos_ch0", adc_data[13:0], (j <= 5) ? 14'h1FFF : 14'h0100);
        end

        // or_clr alone
        or_clr = 1'b1;
        tick();
        or_clr = 1'b0;
        chk("clr_sticky", or_sticky[0], 1'b0);
        chk("clr_cnt", or_cnt[1:0], 2'd0);

        // or_clr coincident with a stage-1 overrange bit
        adc_or = 2'b01;
        tick();
        tick();
        tick();
        chk("pre_clr_cnt", or_cnt[1:0], 2'd2);
        adc_or = 2'b00;
        or_clr = 1'b1;
        tick();
        or_clr = 1'b0;
        chk("clr_coinc_sticky", or_sticky[0], 1'b1);
        chk("clr_coinc_cnt", or_cnt[1:0], 2'd1);
        tick();
        chk("clr_coinc_cnt_hold", or_cnt[1:0], 2'd1);

        // Negative clamp on ch1
        adc_d  = {14'h0100, 14'h2100};
        adc_or = 2'b10;
        tick();
        adc_or = 2'b00;
        tick();
        chk("clamp_neg_ch1", adc_data[27:14], 14'h2000);
        chk("sticky_both", or_sticky, 2'b11);

        // Normal burst
        s0[0] = -5;  s0[1] = 3;    s0[2] = 7;  s0[3] = -8;
        s1[0] = 100; s1[1] = -200; s1[2] = 50; s1[3] = 0;
        burst(4, -1, -1);
        chk("peak_ch0_is_8", peak_abs[13:0], 14'd8);

        // Zero-length request is ignored
        n_valid = 0;
        n_done  = 0;
        cap_start = 1'b1;
        cap_len   = '0;
        tick();
        cap_start = 1'b0;
        repeat (5) tick();
        chk("zero_len_valid", n_valid, 0);
        chk("zero_len_done", n_done, 0);
        chk("zero_len_busy", cap_busy, 1'b0);

        // len=10 with an ignored second start at sample 3; includes -full-scale
        for (int i = 0; i < 128; i++) begin
            s0[i] = i * 100 - 300;
            s1[i] = (i == 6) ? -8192 : i * 7;
        end
        burst(10, -1, 4);
        chk("peak_fullscale_ch1", peak_abs[27:14], 14'h2000);

        // Abort after 20 of 100 samples: peak must be kept
        for (int i = 0; i < 128; i++) begin
            s0[i] = i * 37 - 1800;
            s1[i] = -i * 50;
        end
        burst(100, 20, -1);

        // Start and abort together in IDLE
        n_valid = 0;
        n_done  = 0;
        cap_start = 1'b1;
        cap_len   = 16'd5;
        cap_abort = 1'b1;
        tick();
        cap_start = 1'b0;
        cap_abort = 1'b0;
        repeat (8) tick();
        chk("start_abort_valid", n_valid, 0);
        chk("start_abort_done", n_done, 0);
        chk("start_abort_busy", cap_busy, 1'b0);

        // Asynchronous reset in the middle of a burst
        adc_d = {raw_of(10), raw_of(-20)};
        repeat (3) tick();
        for (int i = 0; i < 50; i++)
            q_cap.push_back({exp_conv(raw_of(10), 1'b0), exp_conv(raw_of(-20), 1'b0)});
        cap_start = 1'b1;
        cap_len   = 16'd50;
        tick();
        cap_start = 1'b0;
        repeat (5) tick();
        chk("midburst_busy", cap_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {cap_valid, cap_busy, cap_done, or_sticky}, '0);
        chk("arst_data", {adc_data, cap_data}, '0);
        chk("arst_peak_cnt", {peak_abs, or_cnt}, '0);
        q_adc.delete();
        q_cap.delete();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle_after", {cap_busy, cap_valid}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
